cmp_result_monitor: RTL and testbench



---
 rtl/cmp_result_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_cmp_result_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// cmp_result_monitor
//
// Purpose:
//   Consumes the one-hot equal/greater/less flags of a 4-bit magnitude
//   comparator and turns them into a debounced relation state. The block:
//     - commits a new stable relation once DEBOUNCE consecutive identical
//       legal samples have been seen, pulsing change_pulse for one cycle,
//     - keeps saturating per-class occurrence counters,
//     - flags samples whose flags are not one-hot.
//
// Parameters:
//   DEBOUNCE  consecutive identical legal samples needed to commit (1..15)
//   CNT_W     width of each occurrence counter
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      flags are sampled on this edge when high
//   equal         comparator equal flag
//   greater       comparator greater flag
//   less          comparator less flag
//   clr           synchronous clear of the counters and of err
//   stable_state  00 UNKNOWN, 01 EQ, 10 GT, 11 LT (registered)
//   change_pulse  one-cycle pulse after stable_state changes (registered)
//   eq_cnt        legal EQ samples seen, saturating (registered)
//   gt_cnt        legal GT samples seen, saturating (registered)
//   lt_cnt        legal LT samples seen, saturating (registered)
//   err           illegal flag combination seen (registered)
//
// Build option:
//   CMP_MON_STICKY_ERR_EN  when defined, err stays high after an illegal
//                          sample until clr or reset; otherwise err is a
//                          one-cycle pulse per illegal sample.
// ---------------------------------------------------------------------------
module cmp_result_monitor #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             equal,
  input  logic             greater,
  input  logic             less,
  input  logic             clr,
  output logic [1:0]       stable_state,
  output logic             change_pulse,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_EQ      = 2'b01,
    ST_GT      = 2'b10,
    ST_LT      = 2'b11
  } rel_e;

  localparam logic [3:0]       DEB_C   = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Exactly one of the three flags high (odd parity, but not all three).
  function automatic logic is_one_hot(input logic e, input logic g, input logic l);
    return (e ^ g ^ l) & ~(e & g & l);
  endfunction

  // Saturating increment: the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  rel_e             stable_r, stable_nxt_s;
  rel_e             cand_r, cand_nxt_s;
  rel_e             class_s;
  logic [3:0]       run_r, run_nxt_s;
  logic             commit_s;
  logic             legal_s;
  logic             illegal_s;
  logic             change_pulse_r;
  logic [CNT_W-1:0] eq_cnt_r, gt_cnt_r, lt_cnt_r;
  logic [CNT_W-1:0] eq_nxt_s, gt_nxt_s, lt_nxt_s;
  logic             err_r, err_nxt_s;

  assign legal_s   = in_valid & is_one_hot(equal, greater, less);
  assign illegal_s = in_valid & ~is_one_hot(equal, greater, less);

  // Decode the flag triple into a relation class (UNKNOWN when not one-hot).
  always_comb begin
    class_s = ST_UNKNOWN;
    case ({equal, greater, less})
      3'b100:  class_s = ST_EQ;
      3'b010:  class_s = ST_GT;
      3'b001:  class_s = ST_LT;
      default: class_s = ST_UNKNOWN;
    endcase
  end

  // Debounce next-state: track candidate run length and decide on commit.
  always_comb begin
    cand_nxt_s   = cand_r;
    run_nxt_s    = run_r;
    stable_nxt_s = stable_r;
    commit_s     = 1'b0;
    if (legal_s) begin
      if (class_s == cand_r) begin
        if (run_r >= DEB_C) begin
          run_nxt_s = DEB_C;
        end else begin
          run_nxt_s = run_r + 4'd1;
        end
      end else begin
        cand_nxt_s = class_s;
        run_nxt_s  = 4'd1;
      end
      // Commit is judged on the updated run length so a new state is
      // visible right after the edge sampling the DEBOUNCE-th sample.
      if ((run_nxt_s == DEB_C) && (cand_nxt_s != stable_r)) begin
        stable_nxt_s = cand_nxt_s;
        commit_s     = 1'b1;
      end else begin
        commit_s     = 1'b0;
      end
    end else if (illegal_s) begin
      // A glitch restarts the debounce but never touches the stable state.
      cand_nxt_s = ST_UNKNOWN;
      run_nxt_s  = 4'd0;
    end else begin
      cand_nxt_s = cand_r;
      run_nxt_s  = run_r;
    end
  end

  // Counter next values: clr dominates any same-cycle increment.
  always_comb begin
    eq_nxt_s = eq_cnt_r;
    gt_nxt_s = gt_cnt_r;
    lt_nxt_s = lt_cnt_r;
    if (clr) begin
      eq_nxt_s = '0;
      gt_nxt_s = '0;
      lt_nxt_s = '0;
    end else if (legal_s) begin
      case (class_s)
        ST_EQ:   eq_nxt_s = sat_inc(eq_cnt_r);
        ST_GT:   gt_nxt_s = sat_inc(gt_cnt_r);
        ST_LT:   lt_nxt_s = sat_inc(lt_cnt_r);
        default: eq_nxt_s = eq_cnt_r;
      endcase
    end else begin
      eq_nxt_s = eq_cnt_r;
    end
  end

  // Error flag next value: clr wins over a coincident illegal sample.
  always_comb begin
    err_nxt_s = 1'b0;
    if (clr) begin
      err_nxt_s = 1'b0;
    end else begin
`ifdef CMP_MON_STICKY_ERR_EN
      err_nxt_s = err_r | illegal_s;
`else
      err_nxt_s = illegal_s;
`endif
    end
  end

  // Debounce state registers and the change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r       <= ST_UNKNOWN;
      cand_r         <= ST_UNKNOWN;
      run_r          <= 4'd0;
      change_pulse_r <= 1'b0;
    end else begin
      stable_r       <= stable_nxt_s;
      cand_r         <= cand_nxt_s;
      run_r          <= run_nxt_s;
      change_pulse_r <= commit_s;
    end
  end

  // Occurrence counters and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt_r <= '0;
      gt_cnt_r <= '0;
      lt_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      eq_cnt_r <= eq_nxt_s;
      gt_cnt_r <= gt_nxt_s;
      lt_cnt_r <= lt_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign stable_state = stable_r;
  assign change_pulse = change_pulse_r;
  assign eq_cnt       = eq_cnt_r;
  assign gt_cnt       = gt_cnt_r;
  assign lt_cnt       = lt_cnt_r;
  assign err          = err_r;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_cmp_result_monitor
//
// Directed-vector bench for cmp_result_monitor (DEBOUNCE=3, CNT_W=8).
// Inputs change 1 time unit after a rising edge and outputs are sampled
// there as well, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_cmp_result_monitor;

  localparam int S_UNK = 0;
  localparam int S_EQ  = 1;
  localparam int S_GT  = 2;
  localparam int S_LT  = 3;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       equal;
  logic       greater;
  logic       less;
  logic       clr;
  logic [1:0] stable_state;
  logic       change_pulse;
  logic [7:0] eq_cnt;
  logic [7:0] gt_cnt;
  logic [7:0] lt_cnt;
  logic       err;

  int vectors;
  int miscompares;
  int pulses;

  cmp_result_monitor #(.DEBOUNCE(3), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .equal        (equal),
    .greater      (greater),
    .less         (less),
    .clr          (clr),
    .stable_state (stable_state),
    .change_pulse (change_pulse),
    .eq_cnt       (eq_cnt),
    .gt_cnt       (gt_cnt),
    .lt_cnt       (lt_cnt),
    .err          (err)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample across one rising edge, then count any change pulse.
  task automatic step(input logic v, input logic e, input logic g, input logic l, input logic c);
    in_valid = v;
    equal    = e;
    greater  = g;
    less     = l;
    clr      = c;
    @(posedge clk);
    #1;
    if (change_pulse) pulses++;
  endtask

  task automatic check_cnts(input string tag, input int e, input int g, input int l);
    check_value({tag, "_eq"}, 32'(eq_cnt), 32'(e));
    check_value({tag, "_gt"}, 32'(gt_cnt), 32'(g));
    check_value({tag, "_lt"}, 32'(lt_cnt), 32'(l));
  endtask

  // Directed stimulus sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    pulses      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    equal       = 1'b0;
    greater     = 1'b0;
    less        = 1'b0;
    clr         = 1'b0;

    // Reset state
    #3;
    check_value("rst_state", 32'(stable_state), S_UNK);
    check_value("rst_pulse", 32'(change_pulse), 0);
    check_value("rst_err", 32'(err), 0);
    check_cnts("rst", 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Three EQ samples commit EQ on the third edge
    pulses = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("eq1_state", 32'(stable_state), S_UNK);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("eq2_state", 32'(stable_state), S_UNK);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("eq3_state", 32'(stable_state), S_EQ);
    check_value("eq3_pulse", 32'(change_pulse), 1);
    check_cnts("eq3", 3, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("eq_pulse_end", 32'(change_pulse), 0);
    check_value("eq_pulses", 32'(pulses), 1);

    // GT,GT,EQ,GT,GT,GT: only the last GT commits
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_value("gt_pre_state", 32'(stable_state), S_EQ);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_value("gt_state", 32'(stable_state), S_GT);
    check_value("gt_pulses", 32'(pulses), 1);
    check_cnts("gt", 4, 5, 0);

    // GT, LT, illegal, LT, LT, LT: the glitch restarts the LT run
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_value("ill_err", 32'(err), 1);
    check_value("ill_state", 32'(stable_state), S_GT);
    check_cnts("ill", 4, 6, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("ill_err_end", 32'(err), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("ill_lt2_state", 32'(stable_state), S_GT);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("ill_lt3_state", 32'(stable_state), S_LT);
    check_value("ill_pulses", 32'(pulses), 1);
    check_cnts("ill_done", 4, 6, 4);

    // 300 LT samples saturate lt_cnt at 255 with no further pulses
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 249) check_value("lt_254", 32'(lt_cnt), 254);
      if (i == 250) check_value("lt_255", 32'(lt_cnt), 255);
    end
    check_value("lt_sat", 32'(lt_cnt), 255);
    check_value("lt_sat_pulses", 32'(pulses), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_cnts("clr", 0, 0, 0);
    check_value("clr_state", 32'(stable_state), S_LT);
    check_value("clr_err", 32'(err), 0);

    // From stable GT: LT,LT, 10 idle cycles with toggling flags, then LT
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_value("hold_gt_state", 32'(stable_state), S_GT);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [2:0] f;
      f = 3'(i);
      step(1'b0, f[0], f[1], f[2], 1'b0);
      if (err) check_value("hold_err", 32'(err), 0);
    end
    check_value("hold_state", 32'(stable_state), S_GT);
    check_cnts("hold", 0, 3, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("hold_commit", 32'(stable_state), S_LT);
    check_value("hold_pulses", 32'(pulses), 2);
    check_value("hold_err_end", 32'(err), 0);
    check_cnts("hold_done", 0, 3, 3);

    // Asynchronous reset in the middle of a debounce run
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_value("ar_gt_state", 32'(stable_state), S_GT);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("ar_state", 32'(stable_state), S_UNK);
    check_cnts("ar", 0, 0, 0);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("ar_lt2_state", 32'(stable_state), S_UNK);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("ar_lt3_state", 32'(stable_state), S_LT);
    check_value("ar_pulse", 32'(change_pulse), 1);
    check_cnts("ar_done", 0, 0, 3);

`ifdef CMP_MON_STICKY_ERR_EN
    // Sticky error: held until clr; clr beats a coincident illegal sample
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("sticky_set", 32'(err), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("sticky_hold1", 32'(err), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("sticky_hold2", 32'(err), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_value("sticky_clr_ill", 32'(err), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_value("sticky_reset", 32'(err), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_value("sticky_clr", 32'(err), 0);
`else
    // Pulse error: back-to-back illegal samples keep err high, then it drops
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("perr_1", 32'(err), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_value("perr_2", 32'(err), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("perr_drop", 32'(err), 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_value("perr_clr_ill", 32'(err), 0);
`endif
    check_value("err_state_kept", 32'(stable_state), S_LT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
